// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon permutation engine.
//   STATE_W / WORD_W : permutation state width and word width
//   ROUNDS_MAX       : longest permutation (p^a), sets the constant start index
//   fsm_state_t      : controller states of ascon_perm_iter
//   ascon_state_t    : the five 64-bit state words, x0 in the MSBs
//   round_const()    : per-round constant for constant-table index idx
package ascon_pkg;

    localparam int STATE_W    = 320;
    localparam int WORD_W     = 64;
    localparam int ROUNDS_MAX = 12;

    // Fixed encodings kept as plain constants so older code that compares
    // raw state bits keeps working; the enum below reuses them.
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_RUN_ENC  = 2'd1;
    localparam logic [1:0] ST_DONE_ENC = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE_ENC,
        RUN  = ST_RUN_ENC,
        DONE = ST_DONE_ENC
    } fsm_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] x0;
        logic [WORD_W-1:0] x1;
        logic [WORD_W-1:0] x2;
        logic [WORD_W-1:0] x3;
        logic [WORD_W-1:0] x4;
    } ascon_state_t;

    // idx 0..11 gives f0, e1, d2, ... 4b.
    function automatic logic [7:0] round_const(input logic [3:0] idx);
        return {~idx, idx};
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced 5-bit S-box
// layer, then the per-word linear diffusion layer.
// Ports:
//   state_in  : 320-bit state before the round
//   c_r       : round constant, XORed into the low byte of x2
//   state_out : 320-bit state after the round
module ascon_round
    import ascon_pkg::*;
(
    input  ascon_state_t state_in,
    input  logic [7:0]   c_r,
    output ascon_state_t state_out
);

    function automatic logic [63:0] rotr64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        a0 = state_in.x0;
        a1 = state_in.x1;
        a2 = state_in.x2 ^ {56'd0, c_r};
        a3 = state_in.x3;
        a4 = state_in.x4;

        // Bitsliced S-box: each bit column (x0[i]..x4[i]) is one 5-bit lane.
        a0 = a0 ^ a4;
        a4 = a4 ^ a3;
        a2 = a2 ^ a1;
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;
        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;

        state_out.x0 = a0 ^ rotr64(a0, 19) ^ rotr64(a0, 28);
        state_out.x1 = a1 ^ rotr64(a1, 61) ^ rotr64(a1, 39);
        state_out.x2 = a2 ^ rotr64(a2, 1)  ^ rotr64(a2, 6);
        state_out.x3 = a3 ^ rotr64(a3, 10) ^ rotr64(a3, 17);
        state_out.x4 = a4 ^ rotr64(a4, 7)  ^ rotr64(a4, 41);
    end

endmodule

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation engine. Accepts a state and round count from
// the mode controller, applies UNROLL rounds per clock with the correct
// round constants, and hands the permuted state back.
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid
// RUN   | applying min(UNROLL, rem) rounds per clock
// DONE  | out_valid=1, holding result until out_ready
//
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid / in_ready : input handshake; in_ready high only in IDLE
//   rounds              : requested rounds 0..12, larger values clamp to 12
//   x0_in..x4_in        : input state words, sampled on the accept edge
//   out_valid/out_ready : output handshake; out_valid high only in DONE
//   x0_out..x4_out      : state register contents
//   busy                : high in RUN or DONE
module ascon_perm_iter
    import ascon_pkg::*;
#(
    parameter int UNROLL     = 1,
    parameter int ROUNDS_MAX = ascon_pkg::ROUNDS_MAX
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  rounds,
    input  logic [63:0] x0_in,
    input  logic [63:0] x1_in,
    input  logic [63:0] x2_in,
    input  logic [63:0] x3_in,
    input  logic [63:0] x4_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] x0_out,
    output logic [63:0] x1_out,
    output logic [63:0] x2_out,
    output logic [63:0] x3_out,
    output logic [63:0] x4_out,
    output logic        busy
);

    if ((UNROLL != 1) && (UNROLL != 2)) begin : g_bad_unroll
        $error("ascon_perm_iter: UNROLL must be 1 or 2");
    end

    fsm_state_t   st;
    ascon_state_t sreg;
    logic [3:0]   idx;
    logic [3:0]   rem;
    logic [3:0]   r_clamp;
    logic [3:0]   step;
    ascon_state_t next_sreg;
    ascon_state_t chain [UNROLL+1];

    assign chain[0] = sreg;

    // Round u of a clock uses constant index idx+u. When only one round
    // remains with UNROLL=2, idx+1 may reach 12 but that output is unused.
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [7:0] c_r;
        assign c_r = round_const(idx + 4'(u));
        ascon_round u_round (
            .state_in  (chain[u]),
            .c_r       (c_r),
            .state_out (chain[u+1])
        );
    end

    assign r_clamp   = (rounds > 4'(ROUNDS_MAX)) ? 4'(ROUNDS_MAX) : rounds;
    assign step      = (rem < 4'(UNROLL)) ? rem : 4'(UNROLL);
    assign next_sreg = (rem == 4'd1) ? chain[1] : chain[UNROLL];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= IDLE;
            sreg <= '0;
            idx  <= '0;
            rem  <= '0;
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        sreg <= '{x0: x0_in, x1: x1_in, x2: x2_in, x3: x3_in, x4: x4_in};
                        idx  <= 4'(ROUNDS_MAX) - r_clamp;
                        rem  <= r_clamp;
                        st   <= (r_clamp == 4'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    sreg <= next_sreg;
                    idx  <= idx + step;
                    rem  <= rem - step;
                    if (rem == step) begin
                        st <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign in_ready  = (st == IDLE);
    assign out_valid = (st == DONE);
    assign busy      = (st != IDLE);

    assign x0_out = sreg.x0;
    assign x1_out = sreg.x1;
    assign x2_out = sreg.x2;
    assign x3_out = sreg.x3;
    assign x4_out = sreg.x4;

endmodule

// File: tb/tb_ascon_perm_iter.sv
// Bench for ascon_perm_iter: one UNROLL=1 and one UNROLL=2 instance share
// clock, reset and input data; each has its own handshake lines. Results are
// compared against a table-driven Ascon model (S-box lookup per bit column).
module tb_ascon_perm_iter;

    logic        clk;
    logic        rst;
    logic [1:0]  in_valid_v;
    logic [1:0]  in_ready_v;
    logic [1:0]  out_valid_v;
    logic [1:0]  out_ready_v;
    logic [1:0]  busy_v;
    logic [3:0]  rounds;
    logic [63:0] xi [5];
    logic [63:0] xo [2][5];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rc_tab [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                                8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    logic [4:0] sbox_tab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                  5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                  5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                  5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    ascon_perm_iter #(.UNROLL(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .rounds(rounds),
        .x0_in(xi[0]), .x1_in(xi[1]), .x2_in(xi[2]), .x3_in(xi[3]), .x4_in(xi[4]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .x0_out(xo[0][0]), .x1_out(xo[0][1]), .x2_out(xo[0][2]), .x3_out(xo[0][3]), .x4_out(xo[0][4]),
        .busy(busy_v[0])
    );

    ascon_perm_iter #(.UNROLL(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .rounds(rounds),
        .x0_in(xi[0]), .x1_in(xi[1]), .x2_in(xi[2]), .x3_in(xi[3]), .x4_in(xi[4]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .x0_out(xo[1][0]), .x1_out(xo[1][1]), .x2_out(xo[1][2]), .x3_out(xo[1][3]), .x4_out(xo[1][4]),
        .busy(busy_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int r_req);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  col;
        logic [4:0]  sub;
        int r;
        r = (r_req > 12) ? 12 : r_req;
        for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
        for (int i = 0; i < r; i++) begin
            x[2] = x[2] ^ {56'd0, rc_tab[12 - r + i]};
            for (int b = 0; b < 64; b++) begin
                col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                sub = sbox_tab[col];
                for (int w = 0; w < 5; w++) y[w][b] = sub[4 - w];
            end
            for (int w = 0; w < 5; w++) x[w] = y[w] ^ rotr(y[w], rot_a[w]) ^ rotr(y[w], rot_b[w]);
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic int exp_latency(input int r_req, input int u);
        int r;
        r = (r_req > 12) ? 12 : r_req;
        return (r + u - 1) / u;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [319:0] dut_out(input int u);
        return {xo[u][0], xo[u][1], xo[u][2], xo[u][3], xo[u][4]};
    endfunction

    // Drives one operation through instance u (0: UNROLL=1, 1: UNROLL=2),
    // measures edges from acceptance to out_valid, then takes the result.
    task automatic run_op(input int u, input logic [319:0] st, input logic [3:0] rds,
                          output logic [319:0] res, output int lat, output bit ready_seen);
        @(negedge clk);
        {xi[0], xi[1], xi[2], xi[3], xi[4]} = st;
        rounds = rds;
        in_valid_v[u] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[u] = 1'b0;
        lat = 0;
        ready_seen = 1'b0;
        while (out_valid_v[u] !== 1'b1 && lat < 40) begin
            if (in_ready_v[u] === 1'b1) ready_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        res = dut_out(u);
        @(negedge clk);
        out_ready_v[u] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[u] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (in_ready_v[u] !== 1'b1) begin n_errors++; $display("FAIL reset in_ready[%0d]: got %b expected 1", u, in_ready_v[u]); end
            n_checks++;
            if (out_valid_v[u] !== 1'b0) begin n_errors++; $display("FAIL reset out_valid[%0d]: got %b expected 0", u, out_valid_v[u]); end
            n_checks++;
            if (busy_v[u] !== 1'b0) begin n_errors++; $display("FAIL reset busy[%0d]: got %b expected 0", u, busy_v[u]); end
            n_checks++;
            if (dut_out(u) !== 320'd0) begin n_errors++; $display("FAIL reset state[%0d]: got %h expected 0", u, dut_out(u)); end
        end
    endtask

    task automatic test_one_round();
        logic [319:0] res, exp;
        int lat;
        bit rs;
        exp = model_perm(320'd0, 1);
        run_op(0, 320'd0, 4'd1, res, lat, rs);
        n_checks++;
        if (res !== exp) begin n_errors++; $display("FAIL one_round result: got %h expected %h", res, exp); end
        n_checks++;
        if (lat != 1) begin n_errors++; $display("FAIL one_round latency: got %0d expected 1", lat); end
    endtask

    task automatic test_ascon_init();
        logic [319:0] st, res, exp;
        int lat;
        bit rs;
        st = {64'h80400c0600000000, 256'd0};
        exp = model_perm(st, 12);
        run_op(0, st, 4'd12, res, lat, rs);
        n_checks++;
        if (res !== exp) begin n_errors++; $display("FAIL ascon_init result: got %h expected %h", res, exp); end
        n_checks++;
        if (lat != 12) begin n_errors++; $display("FAIL ascon_init latency: got %0d expected 12", lat); end
        n_checks++;
        if (rs !== 1'b0) begin n_errors++; $display("FAIL ascon_init in_ready during run: got %b expected 0", rs); end
    endtask

    task automatic test_passthrough_clamp();
        logic [319:0] st, res, exp;
        int lat;
        bit rs;
        st = {64'h0123456789abcdef, 64'h1032547698badcfe, 64'h2301674589efcdab,
              64'h32107654ba98fedc, 64'h4567012389abcdef};
        run_op(0, st, 4'd0, res, lat, rs);
        n_checks++;
        if (res !== st) begin n_errors++; $display("FAIL passthrough result: got %h expected %h", res, st); end
        n_checks++;
        if (lat != 0) begin n_errors++; $display("FAIL passthrough latency: got %0d expected 0", lat); end
        exp = model_perm(st, 12);
        run_op(0, st, 4'd15, res, lat, rs);
        n_checks++;
        if (res !== exp) begin n_errors++; $display("FAIL clamp15 result: got %h expected %h", res, exp); end
        n_checks++;
        if (lat != 12) begin n_errors++; $display("FAIL clamp15 latency: got %0d expected 12", lat); end
    endtask

    task automatic test_unroll2();
        logic [319:0] st, res, exp;
        int lat;
        bit rs;
        st = rand320();
        for (int k = 0; k < 2; k++) begin
            int r;
            r = (k == 0) ? 6 : 8;
            exp = model_perm(st, r);
            run_op(1, st, 4'(r), res, lat, rs);
            n_checks++;
            if (res !== exp) begin n_errors++; $display("FAIL unroll2 r=%0d result: got %h expected %h", r, res, exp); end
            n_checks++;
            if (lat != r / 2) begin n_errors++; $display("FAIL unroll2 r=%0d latency: got %0d expected %0d", r, lat, r / 2); end
            run_op(0, st, 4'(r), res, lat, rs);
            n_checks++;
            if (res !== exp) begin n_errors++; $display("FAIL unroll1 r=%0d result: got %h expected %h", r, res, exp); end
        end
    endtask

    task automatic test_backpressure();
        logic [319:0] st, held, exp;
        int lat;
        st = rand320();
        exp = model_perm(st, 3);
        @(negedge clk);
        {xi[0], xi[1], xi[2], xi[3], xi[4]} = st;
        rounds = 4'd3;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        lat = 0;
        while (out_valid_v[0] !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        held = dut_out(0);
        n_checks++;
        if (held !== exp) begin n_errors++; $display("FAIL backpressure result: got %h expected %h", held, exp); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            {xi[0], xi[1], xi[2], xi[3], xi[4]} = rand320();
            rounds = 4'($urandom_range(0, 15));
            in_valid_v[0] = c[0];
            @(posedge clk);
            #1;
            in_valid_v[0] = 1'b0;
            n_checks++;
            if (out_valid_v[0] !== 1'b1 || dut_out(0) !== exp || in_ready_v[0] !== 1'b0) begin
                n_errors++;
                $display("FAIL backpressure hold c=%0d: got valid=%b ready=%b state=%h expected valid=1 ready=0 state=%h",
                         c, out_valid_v[0], in_ready_v[0], dut_out(0), exp);
            end
        end
        @(negedge clk);
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[0] = 1'b0;
        n_checks++;
        if (out_valid_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL backpressure release: got valid=%b ready=%b expected valid=0 ready=1", out_valid_v[0], in_ready_v[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [319:0] st, res, exp;
        int lat;
        bit rs;
        bit seen_valid;
        @(negedge clk);
        {xi[0], xi[1], xi[2], xi[3], xi[4]} = rand320();
        rounds = 4'd12;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy_v[0] !== 1'b0 || in_ready_v[0] !== 1'b1 || out_valid_v[0] !== 1'b0 || dut_out(0) !== 320'd0) begin
            n_errors++;
            $display("FAIL midrun reset: got busy=%b ready=%b valid=%b state=%h expected 0/1/0/0",
                     busy_v[0], in_ready_v[0], out_valid_v[0], dut_out(0));
        end
        @(negedge clk);
        rst = 1'b0;
        seen_valid = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (out_valid_v[0] !== 1'b0) seen_valid = 1'b1;
        end
        n_checks++;
        if (seen_valid !== 1'b0) begin n_errors++; $display("FAIL midrun no out_valid after reset: got %b expected 0", seen_valid); end
        st = rand320();
        exp = model_perm(st, 6);
        run_op(0, st, 4'd6, res, lat, rs);
        n_checks++;
        if (res !== exp) begin n_errors++; $display("FAIL after reset r=6 result: got %h expected %h", res, exp); end
        n_checks++;
        if (lat != 6) begin n_errors++; $display("FAIL after reset r=6 latency: got %0d expected 6", lat); end
    endtask

    task automatic test_random();
        logic [319:0] st, res, exp;
        int lat, r, u;
        bit rs;
        for (int i = 0; i < 12; i++) begin
            u = i % 2;
            r = $urandom_range(0, 15);
            st = rand320();
            exp = model_perm(st, r);
            run_op(u, st, 4'(r), res, lat, rs);
            n_checks++;
            if (res !== exp) begin n_errors++; $display("FAIL random[%0d] u=%0d r=%0d result: got %h expected %h", i, u + 1, r, res, exp); end
            n_checks++;
            if (lat != exp_latency(r, u + 1)) begin
                n_errors++;
                $display("FAIL random[%0d] u=%0d r=%0d latency: got %0d expected %0d", i, u + 1, r, lat, exp_latency(r, u + 1));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid_v = 2'b00;
        out_ready_v = 2'b00;
        rounds = 4'd0;
        for (int w = 0; w < 5; w++) xi[w] = 64'd0;
        #1;
        test_reset();
        #20;
        @(negedge clk);
        rst = 1'b0;
        test_one_round();
        test_ascon_init();
        test_passthrough_clamp();
        test_unroll2();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
